// File: rtl/mips_multicycle_ctrl_if.sv
// Control/datapath bundle for the multicycle MIPS main controller.
//   master : the controller (drives strobes, mux selects and ALU control)
//   slave  : the datapath (drives instruction fields, zero flag, memory ready)
// Signals:
//   i_opcode/i_funct  instruction fields from IR
//   i_zf              ALU zero flag
//   i_mem_ready       memory completes the current access
//   o_*               datapath enables, mux selects, ALU control, debug state
interface mips_multicycle_ctrl_if;
    logic [5:0] i_opcode;
    logic [5:0] i_funct;
    logic       i_zf;
    logic       i_mem_ready;
    logic [3:0] o_alu_control;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic [1:0] o_pc_src;
    logic       o_pc_write;
    logic       o_iord;
    logic       o_mem_read;
    logic       o_mem_write;
    logic       o_ir_write;
    logic       o_reg_write;
    logic       o_reg_dst;
    logic       o_mem_to_reg;
    logic       o_illegal;
    logic [3:0] o_state;

    modport master (
        input  i_opcode, i_funct, i_zf, i_mem_ready,
        output o_alu_control, o_alu_src_a, o_alu_src_b, o_pc_src, o_pc_write, o_iord,
               o_mem_read, o_mem_write, o_ir_write, o_reg_write, o_reg_dst, o_mem_to_reg,
               o_illegal, o_state
    );

    modport slave (
        output i_opcode, i_funct, i_zf, i_mem_ready,
        input  o_alu_control, o_alu_src_a, o_alu_src_b, o_pc_src, o_pc_write, o_iord,
               o_mem_read, o_mem_write, o_ir_write, o_reg_write, o_reg_dst, o_mem_to_reg,
               o_illegal, o_state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM. Sequences fetch/decode/execute/writeback,
// issues the 4-bit ALU control and all datapath enables/mux selects.
// Ports:
//   i_clk   rising-edge clock
//   i_rst   asynchronous active-high reset (state -> IDLE, all outputs 0)
//   bus     mips_multicycle_ctrl_if.master (instruction fields, zf, mem ready in;
//           strobes, selects, ALU control, illegal flag, debug state out)
// Parameters:
//   HALT_ON_ILLEGAL  1: illegal opcode/funct -> sticky HALT; 0: skip as NOP
// Configuration macro:
//   MIPS_CTRL_BNE_EN  when defined, bne (000101) branches on ~zf; otherwise illegal.
module mips_multicycle_ctrl #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input logic                   i_clk,
    input logic                   i_rst,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11,
        StJump   = 4'd12,
        StHalt   = 4'd13
    } state_e;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;
`ifdef MIPS_CTRL_BNE_EN
    localparam logic [5:0] OpBne   = 6'b000101;
`endif

    state_e state_q, state_d;

    logic [3:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = StFetch;
        alu_control = 4'b0000;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        pc_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                // PC+4 computed while the instruction is read; commit only on ready.
                mem_read    = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = AluAdd;
                if (bus.i_mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else begin
                    state_d  = StFetch;
                end
            end
            StDecode: begin
                // Branch target precomputed into ALUOut.
                alu_src_b   = 2'b11;
                alu_control = AluAdd;
                case (bus.i_opcode)
                    OpRtype:     state_d = StExec;
                    OpLw, OpSw:  state_d = StMemAdr;
                    OpBeq:       state_d = StBranch;
`ifdef MIPS_CTRL_BNE_EN
                    OpBne:       state_d = StBranch;
`endif
                    OpAddi:      state_d = StAddiEx;
                    OpJ:         state_d = StJump;
                    default: begin
                        illegal = 1'b1;
                        state_d = HALT_ON_ILLEGAL ? StHalt : StFetch;
                    end
                endcase
            end
            StExec: begin
                alu_src_a = 1'b1;
                state_d   = StAluWb;
                case (bus.i_funct)
                    6'b100000: alu_control = AluAdd;
                    6'b100010: alu_control = AluSub;
                    6'b100100: alu_control = AluAnd;
                    6'b100101: alu_control = AluOr;
                    6'b101010: alu_control = AluSlt;
                    6'b100111: alu_control = AluNor;
                    default: begin
                        illegal = 1'b1;
                        state_d = HALT_ON_ILLEGAL ? StHalt : StFetch;
                    end
                endcase
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = StFetch;
            end
            StMemAdr: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = AluAdd;
                state_d     = (bus.i_opcode == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = bus.i_mem_ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = bus.i_mem_ready ? StFetch : StMemWr;
            end
            StBranch: begin
                alu_src_a   = 1'b1;
                alu_control = AluSub;
                pc_src      = 2'b01;
`ifdef MIPS_CTRL_BNE_EN
                pc_write    = (bus.i_opcode == OpBne) ? ~bus.i_zf : bus.i_zf;
`else
                pc_write    = bus.i_zf;
`endif
                state_d     = StFetch;
            end
            StAddiEx: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = AluAdd;
                state_d     = StAddiWb;
            end
            StAddiWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StJump: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = StFetch;
            end
            StHalt: begin
                illegal = 1'b1;
                state_d = StHalt;
            end
            default: state_d = StFetch;
        endcase
    end

    assign bus.o_alu_control = alu_control;
    assign bus.o_alu_src_a   = alu_src_a;
    assign bus.o_alu_src_b   = alu_src_b;
    assign bus.o_pc_src      = pc_src;
    assign bus.o_pc_write    = pc_write;
    assign bus.o_iord        = iord;
    assign bus.o_mem_read    = mem_read;
    assign bus.o_mem_write   = mem_write;
    assign bus.o_ir_write    = ir_write;
    assign bus.o_reg_write   = reg_write;
    assign bus.o_reg_dst     = reg_dst;
    assign bus.o_mem_to_reg  = mem_to_reg;
    assign bus.o_illegal     = illegal;
    assign bus.o_state       = state_q;

endmodule
